dmem_port_arbiter: RTL and testbench

//  Shares the single-port data memory between the core load/store path and a

---
 rtl/dmem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data memory between the core and debug requesters.
// One transaction at a time, round-robin on ties, fixed MEM_LAT read latency.
module dmem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-3:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
    localparam logic CORE = 1'b0;
    localparam logic DBG  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               owner_q, owner_d;
    logic               we_q, we_d;
    logic [ADDR_W-3:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
    logic               gnt_c, gnt_d;
    logic               capture;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^{c_addr[1:0], d_addr[1:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        c_rdata_d = c_rdata_q;
        d_rdata_d = d_rdata_q;
        gnt_c     = 1'b0;
        gnt_d     = 1'b0;
        capture   = 1'b0;
        m_en      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (c_req && d_req) begin
                    gnt_c = (last_q == DBG);
                    gnt_d = (last_q == CORE);
                end else begin
                    gnt_c = c_req;
                    gnt_d = d_req;
                end
                if (gnt_c || gnt_d) begin
                    owner_d = gnt_d;
                    last_d  = gnt_d;
                    we_d    = gnt_d ? d_we : c_we;
                    addr_d  = gnt_d ? d_addr[ADDR_W-1:2] : c_addr[ADDR_W-1:2];
                    wdata_d = gnt_d ? d_wdata : c_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                m_en = 1'b1;
                if (we_q) begin
                    state_d = S_RESP;
                end else if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // read data lands in the owner's holding register only
        if (capture) begin
            if (owner_q == DBG) begin
                d_rdata_d = m_rdata;
            end else begin
                c_rdata_d = m_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            last_q    <= DBG;
            owner_q   <= CORE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // grants are Mealy; mask them so nothing leaks out while held in reset
    assign c_gnt   = gnt_c & areset;
    assign d_gnt   = gnt_d & areset;
    assign c_ack   = (state_q == S_RESP) && (owner_q == CORE);
    assign d_ack   = (state_q == S_RESP) && (owner_q == DBG);
    assign c_rdata = c_rdata_q;
    assign d_rdata = d_rdata_q;
    assign m_we    = m_en & we_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: two instances (MEM_LAT=1 and 3), directed
// scenarios plus random traffic against a cycle-scheduled scoreboard.
module tb_dmem_port_arbiter;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } rq_t;

    logic        clk = 1'b0;
    logic        areset = 1'b0;
    rq_t         c_in [2];
    rq_t         d_in [2];
    logic        c_gnt_o [2];
    logic        d_gnt_o [2];
    logic        c_ack_o [2];
    logic        d_ack_o [2];
    logic        m_en_o [2];
    logic        m_we_o [2];
    logic [31:0] c_rd_o [2];
    logic [31:0] d_rd_o [2];
    logic [31:0] m_wd_o [2];
    logic [31:0] m_rd_i [2];
    logic [29:0] m_addr_o [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;
        bit [31:0] mem [16];
        int age = 0;

        dmem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT(L)
        ) u_dut (
            .clk(clk), .areset(areset),
            .c_req(c_in[g].req), .c_we(c_in[g].we),
            .c_addr(c_in[g].addr), .c_wdata(c_in[g].wd),
            .c_gnt(c_gnt_o[g]), .c_ack(c_ack_o[g]), .c_rdata(c_rd_o[g]),
            .d_req(d_in[g].req), .d_we(d_in[g].we),
            .d_addr(d_in[g].addr), .d_wdata(d_in[g].wd),
            .d_gnt(d_gnt_o[g]), .d_ack(d_ack_o[g]), .d_rdata(d_rd_o[g]),
            .m_en(m_en_o[g]), .m_we(m_we_o[g]), .m_addr(m_addr_o[g]),
            .m_wdata(m_wd_o[g]), .m_rdata(m_rd_i[g])
        );

        // memory drives valid data only in the cycle MEM_LAT-1 after m_en
        always @(posedge clk) begin
            if (m_en_o[g] && m_we_o[g]) mem[m_addr_o[g][3:0]] <= m_wd_o[g];
            age <= m_en_o[g] ? 1 : ((age != 0) ? age + 1 : 0);
        end
        assign m_rd_i[g] =
            ((L == 1 && m_en_o[g]) || (L > 1 && !m_en_o[g] && age == L - 1))
            ? mem[m_addr_o[g][3:0]] : (32'hBAD0_0000 | 32'(age));
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    int          lat_of [2] = '{1, 3};
    int          next_free [2];
    int          ack_cyc [2];
    int          men_cyc [2];
    bit          own [2];
    bit          last [2];
    bit          cur_we [2];
    logic [31:0] cur_addr [2];
    logic [31:0] cur_wd [2];
    logic [31:0] pend_rd [2];
    logic [31:0] exp_rd [2][2];
    bit   [31:0] refm [2][16];
    logic        gs_c [2];
    logic        gs_d [2];

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            logic eg_c, eg_d, em, ea;
            rq_t  w;
            if (!areset) begin
                chk("rst_c_gnt", c_gnt_o[g], 0);
                chk("rst_d_gnt", d_gnt_o[g], 0);
                chk("rst_c_ack", c_ack_o[g], 0);
                chk("rst_d_ack", d_ack_o[g], 0);
                chk("rst_m_en", m_en_o[g], 0);
                chk("rst_m_we", m_we_o[g], 0);
                chk("rst_m_addr", m_addr_o[g], 0);
                chk("rst_m_wdata", m_wd_o[g], 0);
                chk("rst_c_rdata", c_rd_o[g], 0);
                chk("rst_d_rdata", d_rd_o[g], 0);
                next_free[g] = 0;
                ack_cyc[g] = -1;
                men_cyc[g] = -1;
                last[g] = 1'b1;
                own[g] = 1'b0;
                cur_we[g] = 1'b0;
                exp_rd[g][0] = '0;
                exp_rd[g][1] = '0;
                gs_c[g] = 1'b0;
                gs_d[g] = 1'b0;
            end else begin
                eg_c = 1'b0;
                eg_d = 1'b0;
                if (cyc >= next_free[g]) begin
                    if (c_in[g].req && d_in[g].req) begin
                        eg_c = last[g];
                        eg_d = !last[g];
                    end else begin
                        eg_c = c_in[g].req;
                        eg_d = d_in[g].req;
                    end
                end
                chk("c_gnt", c_gnt_o[g], eg_c);
                chk("d_gnt", d_gnt_o[g], eg_d);
                gs_c[g] = c_gnt_o[g];
                gs_d[g] = d_gnt_o[g];

                em = (cyc == men_cyc[g]);
                chk("m_en", m_en_o[g], em);
                chk("m_we", m_we_o[g], em & cur_we[g]);
                if (em) begin
                    chk("m_addr", m_addr_o[g], cur_addr[g][31:2]);
                    chk("m_wdata", m_wd_o[g], cur_wd[g]);
                end

                ea = (cyc == ack_cyc[g]);
                if (ea && !cur_we[g]) exp_rd[g][own[g]] = pend_rd[g];
                chk("c_ack", c_ack_o[g], ea && !own[g]);
                chk("d_ack", d_ack_o[g], ea && own[g]);
                chk("c_rdata", c_rd_o[g], exp_rd[g][0]);
                chk("d_rdata", d_rd_o[g], exp_rd[g][1]);

                if (eg_c || eg_d) begin
                    w = eg_d ? d_in[g] : c_in[g];
                    own[g] = eg_d;
                    last[g] = eg_d;
                    cur_we[g] = w.we;
                    cur_addr[g] = w.addr;
                    cur_wd[g] = w.wd;
                    if (w.we) refm[g][w.addr[5:2]] = w.wd;
                    else pend_rd[g] = refm[g][w.addr[5:2]];
                    men_cyc[g] = cyc + 1;
                    ack_cyc[g] = cyc + (w.we ? 2 : 1 + lat_of[g]);
                    next_free[g] = ack_cyc[g] + 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic gnt_of(int g, bit dbg);
        return dbg ? d_gnt_o[g] : c_gnt_o[g];
    endfunction

    function automatic logic ack_of(int g, bit dbg);
        return dbg ? d_ack_o[g] : c_ack_o[g];
    endfunction

    task automatic set_rq(input int g, input bit dbg, input rq_t r);
        if (dbg) d_in[g] = r;
        else c_in[g] = r;
    endtask

    task automatic drop_rq(input int g, input bit dbg);
        if (dbg) d_in[g].req = 1'b0;
        else c_in[g].req = 1'b0;
    endtask

    task automatic wait_gnt(input int g, input bit dbg, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gnt_of(g, dbg)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("gnt_timeout", 0, 1);
    endtask

    task automatic wait_ack(input int g, input bit dbg, output int lat);
        lat = -1;
        for (int i = 1; i < 50; i++) begin
            @(negedge clk);
            if (ack_of(g, dbg)) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) chk("ack_timeout", 0, 1);
    endtask

    // lat counts cycles from the grant cycle to the ack cycle
    task automatic do_txn(input int g, input bit dbg, input bit we,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd);
        bit ok;
        @(posedge clk); #1;
        set_rq(g, dbg, '{1'b1, we, a, wd});
        wait_gnt(g, dbg, ok);
        lat = -1;
        rd = '0;
        @(posedge clk); #1;
        drop_rq(g, dbg);
        if (ok) begin
            for (int i = 1; i < 50; i++) begin
                @(negedge clk);
                if (ack_of(g, dbg)) begin
                    lat = i;
                    rd = dbg ? d_rd_o[g] : c_rd_o[g];
                    break;
                end
            end
            if (lat < 0) chk("ack_timeout", 0, 1);
        end
    endtask

    function automatic rq_t nxt(rq_t cur, logic granted);
        rq_t r = cur;
        if (cur.req && !granted) begin
            if ($urandom_range(0, 15) == 0) r.req = 1'b0;
            return r;
        end
        r.req = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
            r.req = 1'b1;
            r.we = 1'($urandom_range(0, 1));
            r.addr = $urandom;
            r.wd = $urandom;
        end
        return r;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int          lat, ca, dg, k;
        int          wins [4];
        bit          ok;
        logic        cg_at_dg;
        logic [31:0] rd;

        for (int g = 0; g < 2; g++) begin
            c_in[g] = '0;
            d_in[g] = '0;
        end
        repeat (3) @(posedge clk);
        #1 areset = 1'b1;

        // store then load of the same word on both latencies
        for (int g = 0; g < 2; g++) begin
            do_txn(g, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat, rd);
            chk("st_lat", lat, 2);
            do_txn(g, 1'b0, 1'b0, 32'h0000_0010, 32'h0, lat, rd);
            chk("ld_lat", lat, (g == 0) ? 2 : 4);
            chk("ld_data", rd, 32'hDEAD_BEEF);
        end

        // debug request arrives while core load is in WAIT
        @(posedge clk); #1;
        c_in[1] = '{1'b1, 1'b0, 32'h10, 32'h0};
        wait_gnt(1, 1'b0, ok);
        @(posedge clk); #1;
        c_in[1].req = 1'b0;
        @(posedge clk); #1;
        d_in[1] = '{1'b1, 1'b1, 32'h20, 32'h1234_5678};
        c_in[1] = '{1'b1, 1'b0, 32'h20, 32'h0};
        ca = -1;
        dg = -1;
        cg_at_dg = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (c_ack_o[1]) ca = i;
            if (d_gnt_o[1]) begin
                dg = i;
                cg_at_dg = c_gnt_o[1];
                break;
            end
        end
        chk("d_gnt_after_resp", dg - ca, 1);
        chk("core_loses_tie", cg_at_dg, 0);
        @(posedge clk); #1;
        d_in[1].req = 1'b0;
        wait_gnt(1, 1'b0, ok);
        @(posedge clk); #1;
        c_in[1].req = 1'b0;
        wait_ack(1, 1'b0, lat);
        chk("ld_after_dbg_st", c_rd_o[1], 32'h1234_5678);

        // async reset in the middle of a MEM_LAT=3 read
        @(posedge clk); #1;
        c_in[1] = '{1'b1, 1'b0, 32'h10, 32'h0};
        wait_gnt(1, 1'b0, ok);
        @(posedge clk); #1;
        c_in[1].req = 1'b0;
        @(posedge clk); #3;
        c_in[1].req = 1'b1;
        areset = 1'b0;
        #1;
        chk("arst_c_gnt", c_gnt_o[1], 0);
        chk("arst_c_ack", c_ack_o[1], 0);
        chk("arst_m_en", m_en_o[1], 0);
        chk("arst_m_addr", m_addr_o[1], 0);
        chk("arst_c_rdata", c_rd_o[1], 0);
        @(negedge clk);
        @(posedge clk); #2;
        areset = 1'b1;
        @(negedge clk);
        chk("rst_first_gnt", c_gnt_o[1], 1);
        @(posedge clk); #1;
        c_in[1].req = 1'b0;
        repeat (8) @(posedge clk);

        // both ports requesting continuously from reset
        #1 areset = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        c_in[0] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0};
        d_in[0] = '{1'b1, 1'b1, 32'h0000_0030, 32'hCAFE_0001};
        #1 areset = 1'b1;
        k = 0;
        for (int i = 0; i < 60 && k < 4; i++) begin
            @(negedge clk);
            if (c_gnt_o[0]) wins[k++] = 0;
            else if (d_gnt_o[0]) wins[k++] = 1;
        end
        chk("rr_count", k, 4);
        for (int i = 0; i < 4; i++) chk("rr_order", wins[i], i % 2);
        @(posedge clk); #1;
        c_in[0].req = 1'b0;
        d_in[0].req = 1'b0;
        repeat (8) @(posedge clk);

        // random traffic on both instances
        repeat (4000) begin
            @(posedge clk); #1;
            for (int g = 0; g < 2; g++) begin
                c_in[g] = nxt(c_in[g], gs_c[g]);
                d_in[g] = nxt(d_in[g], gs_d[g]);
            end
        end
        @(posedge clk); #1;
        for (int g = 0; g < 2; g++) begin
            c_in[g].req = 1'b0;
            d_in[g].req = 1'b0;
        end
        repeat (10) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
